// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the core sequencer and the execute-stage ALU.
// master = sequencer side, slave = ALU side.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, alu_control, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_control, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, bit-serial SLL/SRL,
// result and zero flag returned through a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_unit_if.slave   bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 zero_q, zero_d;
    logic [XLEN-1:0]      shreg_q, shreg_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic                 left_q, left_d;

    logic                 accept;
    logic                 is_shift;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      shifted;
    logic [XLEN-1:0]      single_res;

    // Single-cycle ops; shift codes only reach here with a zero shift amount.
    function automatic logic [XLEN-1:0] alu_single(
        input logic [3:0]      ctrl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (ctrl)
            OP_ADD:         r = a + b;
            OP_SUB:         r = a - b;
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            OP_XOR:         r = a ^ b;
            OP_SLL, OP_SRL: r = a;
            default:        r = b;
        endcase
        return r;
    endfunction

    assign accept     = bus.in_valid && (state_q == S_IDLE);
    assign is_shift   = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL);
    assign shamt      = bus.op_b[SHAMT_W-1:0];
    assign shifted    = left_q ? (shreg_q << 1) : (shreg_q >> 1);
    assign single_res = alu_single(bus.alu_control, bus.op_a, bus.op_b);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        shreg_d  = shreg_q;
        count_d  = count_q;
        left_d   = left_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_d = bus.op_a;
                        count_d = shamt;
                        left_d  = (bus.alu_control == OP_SLL);
                        state_d = S_SHIFT;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = shifted;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            shreg_q  <= '0;
            count_q  <= '0;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            left_q   <= left_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random ops against an
// arithmetic reference model, including backpressure and mid-shift reset.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            default: return b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
        if ((c == 4'd5 || c == 4'd6) && (b % 32) != 0) return int'(b % 32) + 1;
        return 1;
    endfunction

    // Called at a negedge; returns just after the edge where out_valid was first seen.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        bus.alu_control = c;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_handoff", {31'd0, bus.out_valid}, 32'd0);
        check("in_ready_after_handoff", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        int          lat;
        logic [31:0] exp;
        exp = ref_result(c, a, b);
        issue(c, a, b, lat);
        check({tag, "_latency"}, lat, ref_latency(c, b));
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
        handoff();
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic [3:0]  rc;
        logic [31:0] ra, rb;

        bus.in_valid    = 1'b0;
        bus.alu_control = 4'd0;
        bus.op_a        = 32'd0;
        bus.op_b        = 32'd0;
        bus.out_ready   = 1'b0;

        // Asynchronous reset before any clock edge.
        #3 rst = 1'b1;
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_zero", {31'd0, bus.zero}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_const", bus.result, 32'd0);
        do_op("sub_neg", 4'b0001, 32'd5, 32'd7);
        check("sub_neg_const", bus.result, 32'hFFFF_FFFE);
        do_op("sub_equal", 4'b0001, 32'h1234_5678, 32'h1234_5678);
        do_op("and", 4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_const", bus.result, 32'hF000_F000);
        do_op("or", 4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or_const", bus.result, 32'hFFF0_FFF0);
        do_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("xor_const", bus.result, 32'h0FF0_0FF0);
        do_op("pass", 4'b1000, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        do_op("pass_1111", 4'b1111, 32'hDEAD_BEEF, 32'h0BAD_CAFE);
        do_op("sll_max", 4'b0101, 32'd1, 32'h0000_003F);
        check("sll_max_const", bus.result, 32'h8000_0000);
        do_op("srl_4", 4'b0110, 32'h8000_0000, 32'd4);
        check("srl_4_const", bus.result, 32'h0800_0000);
        do_op("sll_zero", 4'b0101, 32'hA5A5_0001, 32'hFFFF_FFE0);
        do_op("srl_to_zero", 4'b0110, 32'h0000_0100, 32'd9);

        for (int i = 0; i < 30; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ra;
            do_op("rand", rc, ra, rb);
        end

        // Backpressure: result held while the consumer stalls.
        issue(4'b0000, 32'd100, 32'd23, lat);
        check("bp_latency", lat, 1);
        held = bus.result;
        check("bp_result", held, 32'd123);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid    = ~bus.in_valid;
            bus.alu_control = 4'($urandom_range(0, 15));
            bus.op_a        = $urandom;
            bus.op_b        = $urandom;
            @(posedge clk);
            #1;
            check("bp_result_stable", bus.result, held);
            check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
            check("bp_out_valid_high", {31'd0, bus.out_valid}, 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        handoff();
        do_op("after_bp", 4'b0011, 32'h0000_00F0, 32'h0000_000F);

        // Reset in the middle of a 20-step shift.
        bus.alu_control = 4'b0110;
        bus.op_a        = 32'hFFFF_0000;
        bus.op_b        = 32'd20;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("mid_shift_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("mid_shift_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        @(negedge clk);
        do_op("post_rst_add", 4'b0000, 32'd40, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
